// File: rtl/stall_controller_if.sv
// Handshake bundle between the pipeline hazard/cache logic and the stall controller.
// The master side raises hazard/cache status; the slave side returns per-cycle pipeline controls.
interface stall_controller_if;
    logic bubble_req;
    logic branch_taken;
    logic icache_read;
    logic icache_resp;
    logic dcache_read;
    logic dcache_write;
    logic dcache_resp;
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic insert_bubble;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;

    modport master (
        output bubble_req, branch_taken, icache_read, icache_resp,
               dcache_read, dcache_write, dcache_resp,
        input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               insert_bubble, flush_if_id, flush_id_ex, flush_ex_mem
    );

    modport slave (
        input  bubble_req, branch_taken, icache_read, icache_resp,
               dcache_read, dcache_write, dcache_resp,
        output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               insert_bubble, flush_if_id, flush_id_ex, flush_ex_mem
    );
endinterface

// File: rtl/stall_controller.sv
// Pipeline stall/flush controller: fixed-priority per-cycle controls, a stall-tracking FSM,
// a pending wrong-path fetch kill flag and saturating performance counters.
module stall_controller #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    stall_controller_if.slave  bus,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   stall_events,
    output logic [CNT_W-1:0]   bubble_count,
    output logic [CNT_W-1:0]   flush_count,
    output logic               kill_pending_o,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_I_WAIT = 2'd1,
        ST_D_WAIT = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != CNT_MAX)) begin
            return v + CNT_ONE;
        end else begin
            return v;
        end
    endfunction

    state_e           state_q, state_d;
    logic             kill_q, kill_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_events_q, bubble_count_q, flush_count_q;

    logic dstall_s, istall_s, branch_s, bubble_s, kill_clr_s, kill_set_s;
    logic stall_cnt_en_s, event_en_s;

    assign dstall_s   = (bus.dcache_read | bus.dcache_write) & ~bus.dcache_resp;
    assign istall_s   = bus.icache_read & ~bus.icache_resp;
    assign branch_s   = ~dstall_s & bus.branch_taken;
    assign bubble_s   = ~dstall_s & ~bus.branch_taken & ~istall_s & bus.bubble_req;
    // A branch resolved while a fetch is stuck leaves that fetch's data to be thrown away later.
    assign kill_set_s = branch_s & istall_s;
    assign kill_clr_s = kill_q & bus.icache_read & bus.icache_resp & ~dstall_s;

    assign stall_cnt_en_s = dstall_s | (istall_s & ~bus.branch_taken);
    assign event_en_s     = ((state_q == ST_RUN) && (state_d != ST_RUN)) ||
                            ((state_q == ST_I_WAIT) && (state_d == ST_D_WAIT));

    // Per-cycle pipeline controls by fixed priority dstall > branch > istall > bubble > run.
    always_comb begin
        bus.load_pc       = 1'b1;
        bus.load_if_id    = 1'b1;
        bus.load_id_ex    = 1'b1;
        bus.load_ex_mem   = 1'b1;
        bus.load_mem_wb   = 1'b1;
        bus.insert_bubble = 1'b0;
        bus.flush_if_id   = 1'b0;
        bus.flush_id_ex   = 1'b0;
        bus.flush_ex_mem  = 1'b0;
        if (dstall_s) begin
            bus.load_pc     = 1'b0;
            bus.load_if_id  = 1'b0;
            bus.load_id_ex  = 1'b0;
            bus.load_ex_mem = 1'b0;
            bus.load_mem_wb = 1'b0;
        end else if (bus.branch_taken) begin
            bus.flush_if_id  = 1'b1;
            bus.flush_id_ex  = 1'b1;
            bus.flush_ex_mem = 1'b1;
        end else if (istall_s) begin
            bus.load_pc     = 1'b0;
            bus.load_if_id  = 1'b0;
            bus.load_id_ex  = 1'b0;
            bus.load_ex_mem = 1'b0;
            bus.load_mem_wb = 1'b0;
        end else if (bus.bubble_req) begin
            bus.load_pc       = 1'b0;
            bus.load_if_id    = kill_clr_s;
            bus.flush_if_id   = kill_clr_s;
            bus.insert_bubble = 1'b1;
        end else begin
            bus.flush_if_id = kill_clr_s;
        end
    end

    // Next-state selection for the stall FSM and the kill flag.
    always_comb begin
        state_d = ST_RUN;
        kill_d  = kill_q;
        if (dstall_s) begin
            state_d = ST_D_WAIT;
        end else if (istall_s && !bus.branch_taken) begin
            state_d = ST_I_WAIT;
        end else begin
            state_d = ST_RUN;
        end
        if (kill_set_s) begin
            kill_d = 1'b1;
        end else if (kill_clr_s) begin
            kill_d = 1'b0;
        end else begin
            kill_d = kill_q;
        end
    end

    // State, kill flag and saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            kill_q         <= 1'b0;
            stall_cycles_q <= '0;
            stall_events_q <= '0;
            bubble_count_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            kill_q         <= kill_d;
            stall_cycles_q <= sat_inc(stall_cycles_q, stall_cnt_en_s);
            stall_events_q <= sat_inc(stall_events_q, event_en_s);
            bubble_count_q <= sat_inc(bubble_count_q, bubble_s);
            flush_count_q  <= sat_inc(flush_count_q, branch_s);
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign stall_events   = stall_events_q;
    assign bubble_count   = bubble_count_q;
    assign flush_count    = flush_count_q;
    assign kill_pending_o = kill_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_stall_controller.sv
// Directed bench for stall_controller: expected control words are queued as each step is
// driven and compared at the negative edge; counters and state are checked after the edge.
module tb_stall_controller;

    localparam int CNT_W = 16;

    // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, insert_bubble, flush_if_id, flush_id_ex, flush_ex_mem}
    localparam logic [8:0] C_RUN      = 9'b11111_0_000;
    localparam logic [8:0] C_FREEZE   = 9'b00000_0_000;
    localparam logic [8:0] C_BUBBLE   = 9'b00111_1_000;
    localparam logic [8:0] C_BRANCH   = 9'b11111_0_111;
    localparam logic [8:0] C_KILL     = 9'b11111_0_100;
    localparam logic [8:0] C_KILL_BUB = 9'b01111_1_100;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } sb_item_t;

    logic             clk;
    logic             reset;
    logic [CNT_W-1:0] stall_cycles, stall_events, bubble_count, flush_count;
    logic             kill_pending;
    logic [1:0]       state;
    int               passed;
    int               total;
    sb_item_t         sb_q[$];

    stall_controller_if bus();

    stall_controller #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .stall_cycles   (stall_cycles),
        .stall_events   (stall_events),
        .bubble_count   (bubble_count),
        .flush_count    (flush_count),
        .kill_pending_o (kill_pending),
        .state_o        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_in(input logic [6:0] in);
        {bus.bubble_req, bus.branch_taken, bus.icache_read, bus.icache_resp,
         bus.dcache_read, bus.dcache_write, bus.dcache_resp} = in;
    endtask

    // in = {bubble_req, branch_taken, icache_read, icache_resp, dcache_read, dcache_write, dcache_resp}
    task automatic step(input string tag, input logic [6:0] in, input logic [8:0] exp);
        sb_item_t it;
        set_in(in);
        sb_q.push_back('{tag, exp});
        @(negedge clk);
        it = sb_q.pop_front();
        check(it.tag, 32'({bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem,
                          bus.load_mem_wb, bus.insert_bubble, bus.flush_if_id,
                          bus.flush_id_ex, bus.flush_ex_mem}), 32'(it.exp));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int sc, input int se, input int bc, input int fc);
        check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(sc));
        check({tag, "_stall_events"}, 32'(stall_events), 32'(se));
        check({tag, "_bubble_count"}, 32'(bubble_count), 32'(bc));
        check({tag, "_flush_count"},  32'(flush_count),  32'(fc));
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        set_in(7'b0000000);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_state", 32'(state), 32'd0);
        check("reset_kill", 32'(kill_pending), 32'd0);
        chk_cnt("reset", 0, 0, 0, 0);

        step("run", 7'b0000000, C_RUN);
        step("load_use", 7'b1000000, C_BUBBLE);
        chk_cnt("load_use", 0, 0, 1, 0);

        step("dmiss1", 7'b0000100, C_FREEZE);
        check("dmiss_state", 32'(state), 32'd2);
        step("dmiss2", 7'b0000100, C_FREEZE);
        step("dmiss3", 7'b0000100, C_FREEZE);
        step("dmiss_resp", 7'b0000101, C_RUN);
        check("dmiss_done_state", 32'(state), 32'd0);
        chk_cnt("dmiss", 3, 1, 1, 0);

        step("br_vs_bubble", 7'b1100000, C_BRANCH);
        chk_cnt("br_vs_bubble", 3, 1, 1, 1);

        step("imiss", 7'b0010000, C_FREEZE);
        check("imiss_state", 32'(state), 32'd1);
        step("br_in_imiss", 7'b0110000, C_BRANCH);
        check("br_in_imiss_kill", 32'(kill_pending), 32'd1);
        check("br_in_imiss_state", 32'(state), 32'd0);
        chk_cnt("br_in_imiss", 4, 2, 1, 2);
        step("imiss_again", 7'b0010000, C_FREEZE);
        step("i_to_d", 7'b0010100, C_FREEZE);
        check("i_to_d_state", 32'(state), 32'd2);
        step("kill_hold_dstall", 7'b0011100, C_FREEZE);
        check("kill_hold_dstall", 32'(kill_pending), 32'd1);
        chk_cnt("kill_hold", 7, 4, 1, 2);
        step("kill_resp", 7'b0011000, C_KILL);
        check("kill_cleared", 32'(kill_pending), 32'd0);
        check("kill_resp_state", 32'(state), 32'd0);

        step("dmiss_b", 7'b0000100, C_FREEZE);
        step("d_to_i", 7'b0010000, C_FREEZE);
        check("d_to_i_state", 32'(state), 32'd1);
        chk_cnt("d_to_i", 9, 5, 1, 2);
        step("idle", 7'b0000000, C_RUN);

        step("branch_a", 7'b0110000, C_BRANCH);
        step("second_branch", 7'b0110000, C_BRANCH);
        check("second_branch_kill", 32'(kill_pending), 32'd1);
        step("kill_with_bubble", 7'b1011000, C_KILL_BUB);
        check("kill_with_bubble_kill", 32'(kill_pending), 32'd0);
        chk_cnt("kill_with_bubble", 9, 5, 2, 4);

        step("branch_b", 7'b0110000, C_BRANCH);
        step("dmiss_pre_reset", 7'b0000100, C_FREEZE);
        check("pre_reset_kill", 32'(kill_pending), 32'd1);
        chk_cnt("pre_reset", 10, 6, 2, 5);
        reset = 1'b1;
        step("reset_cycle", 7'b0000100, C_FREEZE);
        reset = 1'b0;
        check("mid_reset_state", 32'(state), 32'd0);
        check("mid_reset_kill", 32'(kill_pending), 32'd0);
        chk_cnt("mid_reset", 0, 0, 0, 0);
        step("after_reset", 7'b0000000, C_RUN);
        check("after_reset_state", 32'(state), 32'd0);
        chk_cnt("after_reset", 0, 0, 0, 0);

        set_in(7'b1000000);
        for (int i = 0; i < 65541; i++) begin
            @(posedge clk);
        end
        #1;
        chk_cnt("saturate", 0, 0, 65535, 0);
        step("saturate_hold", 7'b1000000, C_BUBBLE);
        check("saturate_hold_count", 32'(bubble_count), 32'hFFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
